// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit with sub-word extraction and read-modify-write stores
module lsu (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] StData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LdData,
  output logic        AdErr,
  output logic [29:0] DmAd,
  output logic [31:0] DmWrData,
  output logic        DMWr,
  input  logic [31:0] DmRd
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] st_q;
  logic        err_q;
  logic [29:0] dmad_q;
  logic [31:0] wrdata_q;
  logic [31:0] lddata_q;

  logic        misalign;
  logic        accept;
  logic        sub_store;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign accept    = (state_q == IDLE) && Req;
  assign sub_store = (op_q == OP_SH) || (op_q == OP_SB);

  // Alignment check on the incoming request: words need Addr[1:0]=0, halves need Addr[0]=0
  always_comb begin
    misalign = 1'b0;
    case (Op)
      OP_LW, OP_SW:         misalign = (Addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign = Addr[0];
      default:              misalign = 1'b0;
    endcase
  end

  // Next-state logic; misaligned requests skip the memory entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Req) begin
          if (misalign)          state_d = DONE;
          else if (Op == OP_SW)  state_d = WR;
          else                   state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = sub_store ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction of the read word with sign or zero extension
  always_comb begin
    byte_v = DmRd[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? DmRd[31:16] : DmRd[15:0];
    case (op_q)
      OP_LH:   ld_ext = {{16{half_v[15]}}, half_v};
      OP_LHU:  ld_ext = {16'h0000, half_v};
      OP_LB:   ld_ext = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ld_ext = {24'h000000, byte_v};
      default: ld_ext = DmRd;
    endcase
  end

  // Merge store lane(s) into the read word, keeping every other bit
  always_comb begin
    merged = DmRd;
    if (op_q == OP_SB) begin
      merged[{lane_q, 3'b000} +: 8] = st_q[7:0];
    end else if (op_q == OP_SH) begin
      if (lane_q[1]) merged[31:16] = st_q;
      else           merged[15:0]  = st_q;
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, write-word build and load-result capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_q     <= OP_LW;
      lane_q   <= 2'b00;
      st_q     <= 16'h0000;
      err_q    <= 1'b0;
      dmad_q   <= 30'h0;
      wrdata_q <= 32'h0;
      lddata_q <= 32'h0;
    end else begin
      if (accept) begin
        op_q   <= Op;
        lane_q <= Addr[1:0];
        st_q   <= StData[15:0];
        err_q  <= misalign;
        dmad_q <= Addr[31:2];
        if (Op == OP_SW) wrdata_q <= StData;
      end
      if (state_q == CAP) begin
        if (sub_store) wrdata_q <= merged;
        else           lddata_q <= ld_ext;
      end
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign AdErr    = (state_q == DONE) && err_q;
  assign DMWr     = (state_q == WR) && !Rst;
  assign DmAd     = dmad_q;
  assign DmWrData = wrdata_q;
  assign LdData   = lddata_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: none; byte order fixed little-endian, lane k = Addr[1:0] = k occupies word bits [8k+7:8k].
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Rst  in  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 Req  in  1  access request; sampled only in IDLE.
REQ-005 Op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 Addr  in  32  byte address.
REQ-007 StData  in  32  store data; SH uses [15:0], SB uses [7:0].
REQ-008 Busy  out  1  high whenever state != IDLE.
REQ-009 Done  out  1  one-cycle completion pulse.
REQ-010 LdData  out  32  extended load result; valid from the Done cycle, held until the next load completes.
REQ-011 AdErr  out  1  misalignment flag; high only together with Done.
REQ-012 DmAd  out  30  word address to data memory; equals latched Addr[31:2].
REQ-013 DmWrData  out  32  write word to data memory.
REQ-014 DMWr  out  1  data memory write enable.
REQ-015 DmRd  in  32  data memory read word; registered by memory, valid one cycle after DmAd is presented with DMWr=0.

Function
REQ-016 States SHALL be IDLE, RD, CAP, WR, DONE.
REQ-017 In IDLE with Req=1, Op, Addr and StData SHALL be latched at the edge; Req outside IDLE SHALL be ignored, never queued.
REQ-018 Misaligned access SHALL be: word op with Addr[1:0]!=0; half op with Addr[0]!=0.
REQ-019 Misaligned: IDLE->DONE; Done=AdErr=1 at n+1; DMWr never asserted; LdData unchanged.
REQ-020 SW aligned: IDLE->WR->DONE; DMWr=1, DmWrData=StData at n+1; Done at n+2.
REQ-021 Loads aligned: IDLE->RD->CAP->DONE; DmRd lane extraction registered into LdData at end of CAP; Done at n+3.
REQ-022 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LH/LHU half select = Addr[1].
REQ-023 SB/SH: IDLE->RD->CAP->WR->DONE; CAP SHALL merge selected StData lane(s) into DmRd, all other bits preserved; WR drives merged word with DMWr=1 at n+3; Done at n+4.
REQ-024 DMWr SHALL be 1 only in WR and only when Rst=0 that cycle; exactly one cycle per store.
REQ-025 DmAd SHALL stay constant from RD/WR entry through DONE.
REQ-026 DONE SHALL last one cycle, then IDLE; new Req accepted the following cycle at earliest.
REQ-027 AdErr SHALL be 0 on aligned completion.

Reset
REQ-028 Rst=1 at an edge SHALL force IDLE and Busy=0, Done=0, AdErr=0, LdData=0, DmAd=0, DmWrData=0; Rst wins over simultaneous Req.
REQ-029 Rst during any state SHALL abandon the access with no Done; Rst during WR SHALL suppress that write (DMWr=0).

Verification
REQ-030 Word1=0x80F17F02: LW 0x4 -> 0x80F17F02; LB 0x6 -> 0xFFFFFFF1; LBU 0x6 -> 0x000000F1; LH 0x6 -> 0xFFFF80F1; LHU 0x4 -> 0x00007F02; each Done at n+3.
REQ-031 SB 0x5, StData=0x000000AA, word1=0x80F17F02 -> DMWr one cycle at n+3 with 0x80F1AA02, Done n+4; LW 0x4 reads 0x80F1AA02.
REQ-032 SH 0x6, StData=0x00001234 -> word1 becomes 0x12347F02; SW 0x8 0xDEADBEEF -> DMWr at n+1, Done n+2.
REQ-033 LW 0x6 and SH 0x5 -> Done=AdErr=1 at n+1, DMWr never 1, memory and LdData unchanged.
REQ-034 SB 0x5 with Rst=1 in its WR cycle -> DMWr=0, word1 unchanged, no Done, all outputs 0 next cycle.
REQ-035 Req held high during a busy LW -> only one access performed; second access starts at the cycle after DONE.
